// File: rtl/isp_awb_pkg.sv
// Shared types and sizing helpers for the AWB gain calculator.
package isp_awb_pkg;

    function automatic int qw_of(input int stat_bits, input int gain_frac);
        return stat_bits + gain_frac;
    endfunction

    function automatic int unity_of(input int gain_frac);
        return 1 << gain_frac;
    endfunction

    function automatic int sat_of(input int gain_bits);
        return (1 << gain_bits) - 1;
    endfunction

    localparam int STAT_BITS_DEF = 32;
    localparam int GAIN_BITS_DEF = 8;
    localparam int GAIN_FRAC_DEF = 4;
    localparam int QW            = qw_of(STAT_BITS_DEF, GAIN_FRAC_DEF);
    localparam int UNITY_GAIN    = unity_of(GAIN_FRAC_DEF);
    localparam int SAT_GAIN      = sat_of(GAIN_BITS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_R = 2'd1,
        DIV_B = 2'd2,
        LOAD  = 2'd3
    } awb_state_e;

endpackage

// File: rtl/isp_seq_div.sv
// Restoring serial divider, one quotient bit per cycle, MSB first.
// The first iteration runs on the start edge so a QW-bit quotient takes exactly QW edges.
module isp_seq_div #(
    parameter int STAT_BITS = isp_awb_pkg::STAT_BITS_DEF,
    parameter int QW        = isp_awb_pkg::QW
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [QW-1:0]        dividend,
    input  logic [STAT_BITS-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [QW-1:0]        quotient
);
    localparam int CW = $clog2(QW + 1);

    logic [QW-1:0] rem_q, rem_in, rem_nx;
    logic [QW-1:0] dvd_q, dvd_in;
    logic [QW-1:0] quo_q;
    logic [QW:0]   rem_sh, dsr_ext;
    logic [CW-1:0] cnt_q;
    logic          busy_q, ge;

    // A zero divisor makes every trial subtraction succeed, so the quotient saturates to all ones.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        dvd_in  = start ? dividend : dvd_q;
        dsr_ext = {{(QW + 1 - STAT_BITS){1'b0}}, divisor};
        rem_sh  = {rem_in, dvd_in[QW-1]};
        ge      = (rem_sh >= dsr_ext);
        rem_nx  = ge ? QW'(rem_sh - dsr_ext) : rem_sh[QW-1:0];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start || busy_q) begin
            rem_q <= rem_nx;
            dvd_q <= {dvd_in[QW-2:0], 1'b0};
            quo_q <= start ? {{(QW-1){1'b0}}, ge} : {quo_q[QW-2:0], ge};
            if (start) begin
                cnt_q  <= CW'(QW - 1);
                busy_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    busy_q <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CW'(1));
    assign quotient = quo_q;

endmodule

// File: rtl/isp_awb_gain_calc.sv
// Gray-world AWB gains G/R and G/B from per-frame statistics, sharing one serial divider.
//   state | meaning
//   IDLE  | waiting for in_done; gains held
//   DIV_R | dividing (sum_g << frac) by sum_r, or dropping a cnt==0 frame
//   DIV_B | dividing (sum_g << frac) by sum_b
//   LOAD  | saturate and load gains, pulse out_valid next cycle
module isp_awb_gain_calc
    import isp_awb_pkg::*;
#(
    parameter int STAT_BITS = STAT_BITS_DEF,
    parameter int GAIN_BITS = GAIN_BITS_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 in_done,
    input  logic [STAT_BITS-1:0] in_cnt,
    input  logic [STAT_BITS-1:0] in_sum_r,
    input  logic [STAT_BITS-1:0] in_sum_g,
    input  logic [STAT_BITS-1:0] in_sum_b,
    output logic [GAIN_BITS-1:0] out_r_gain,
    output logic [GAIN_BITS-1:0] out_g_gain,
    output logic [GAIN_BITS-1:0] out_b_gain,
    output logic                 out_valid,
    output logic                 out_busy
);
    localparam int                   QW_L  = qw_of(STAT_BITS, GAIN_FRAC);
    localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(unity_of(GAIN_FRAC));
    localparam logic [QW_L-1:0]      SAT_Q = QW_L'(sat_of(GAIN_BITS));

    awb_state_e             state_q, state_d;
    logic [STAT_BITS-1:0]   cnt_q, sum_r_q, sum_g_q, sum_b_q;
    logic [QW_L-1:0]        q_r_q, div_quotient, div_dividend;
    logic [STAT_BITS-1:0]   div_divisor;
    logic [GAIN_BITS-1:0]   r_gain_q, b_gain_q;
    logic                   valid_q, div_start, div_busy, div_done;

    function automatic logic [GAIN_BITS-1:0] saturate(input logic [QW_L-1:0] q);
        return (q > SAT_Q) ? SAT_Q[GAIN_BITS-1:0] : q[GAIN_BITS-1:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        div_dividend = {sum_g_q, {GAIN_FRAC{1'b0}}};
        div_divisor  = (state_q == DIV_B) ? sum_b_q : sum_r_q;
        case (state_q)
            IDLE: begin
                if (in_done)
                    state_d = DIV_R;
            end
            DIV_R: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    div_start = !div_busy;
                    if (div_done)
                        state_d = DIV_B;
                end
            end
            DIV_B: begin
                div_start = !div_busy;
                if (div_done)
                    state_d = LOAD;
            end
            LOAD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The R quotient is still in the divider on the first DIV_B cycle; grab it as B starts.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sum_r_q  <= '0;
            sum_g_q  <= '0;
            sum_b_q  <= '0;
            q_r_q    <= '0;
            r_gain_q <= UNITY;
            b_gain_q <= UNITY;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == LOAD);
            if (state_q == IDLE && in_done) begin
                cnt_q   <= in_cnt;
                sum_r_q <= in_sum_r;
                sum_g_q <= in_sum_g;
                sum_b_q <= in_sum_b;
            end
            if (state_q == DIV_B && !div_busy)
                q_r_q <= div_quotient;
            if (state_q == LOAD) begin
                r_gain_q <= saturate(q_r_q);
                b_gain_q <= saturate(div_quotient);
            end
        end
    end

    isp_seq_div #(
        .STAT_BITS (STAT_BITS),
        .QW        (QW_L)
    ) u_div (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign out_r_gain = r_gain_q;
    assign out_g_gain = UNITY;
    assign out_b_gain = b_gain_q;
    assign out_valid  = valid_q;
    assign out_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_isp_awb_gain_calc.sv
// Bench for isp_awb_gain_calc: directed vector table, a back-to-back sequence and random frames.
module tb_isp_awb_gain_calc;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        in_done;
    logic [31:0] in_cnt, in_sum_r, in_sum_g, in_sum_b;
    logic [7:0]  out_r_gain, out_g_gain, out_b_gain;
    logic        out_valid, out_busy;

    always #5 pclk = ~pclk;

    isp_awb_gain_calc dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .in_done    (in_done),
        .in_cnt     (in_cnt),
        .in_sum_r   (in_sum_r),
        .in_sum_g   (in_sum_g),
        .in_sum_b   (in_sum_b),
        .out_r_gain (out_r_gain),
        .out_g_gain (out_g_gain),
        .out_b_gain (out_b_gain),
        .out_valid  (out_valid),
        .out_busy   (out_busy)
    );

    localparam int LAT = 73;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] cur_r = 8'd16;
    logic [7:0] cur_b = 8'd16;

    typedef struct {
        logic [31:0] cnt, sr, sg, sb;
        logic        ev;
        logic [7:0]  er, eb;
        int          inj_at, rst_at;
        string       tag;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Gray-world gain: floor(16*G/D) clipped to 255, divide-by-zero gives 255.
    function automatic logic [7:0] ref_gain(input logic [31:0] g, input logic [31:0] d);
        longint unsigned gg, dd, q;
        gg = g;
        dd = d;
        if (dd == 0) return 8'd255;
        q = (gg * 16) / dd;
        return (q > 255) ? 8'd255 : q[7:0];
    endfunction

    task automatic run_frame(input vec_t v);
        int pulses, first;
        bit stable;
        @(negedge pclk);
        in_cnt = v.cnt; in_sum_r = v.sr; in_sum_g = v.sg; in_sum_b = v.sb;
        in_done = 1'b1;
        @(negedge pclk);
        in_done = 1'b0;
        check({v.tag, " busy_after_start"}, out_busy, 1);
        pulses = 0; first = 0; stable = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            if (v.inj_at != 0 && n == v.inj_at) begin
                in_cnt = 32'd5; in_sum_r = 32'd1; in_sum_g = 32'd100000; in_sum_b = 32'd0;
                in_done = 1'b1;
            end
            if (v.rst_at != 0 && n == v.rst_at) begin
                rst_n = 1'b0;
                #1;
                check({v.tag, " rst_r_gain"}, out_r_gain, 16);
                check({v.tag, " rst_b_gain"}, out_b_gain, 16);
                check({v.tag, " rst_busy"}, out_busy, 0);
                cur_r = 8'd16; cur_b = 8'd16;
            end
            @(negedge pclk);
            in_done = 1'b0;
            rst_n = 1'b1;
            if (n == 1) check({v.tag, " busy_cycle1"}, out_busy, (v.cnt != 0) ? 1 : 0);
            if (out_valid) begin
                pulses++;
                if (first == 0) first = n;
            end
            if (first == 0 && (out_r_gain != cur_r || out_b_gain != cur_b)) stable = 1'b0;
        end
        check({v.tag, " valid_pulses"}, pulses, v.ev ? 1 : 0);
        check({v.tag, " gains_stable_before_load"}, stable, 1);
        if (v.ev) begin
            check({v.tag, " latency"}, first, LAT);
            cur_r = v.er; cur_b = v.eb;
        end
        check({v.tag, " r_gain"}, out_r_gain, cur_r);
        check({v.tag, " b_gain"}, out_b_gain, cur_b);
        check({v.tag, " g_gain"}, out_g_gain, 16);
        check({v.tag, " busy_end"}, out_busy, 0);
    endtask

    initial begin
        vec_t v;
        int first, second;

        tbl[0]  = '{32'd10, 32'd1000, 32'd2000, 32'd4000, 1'b1, 8'd32, 8'd8, 0, 0, "basic"};
        tbl[1]  = '{32'd5, 32'd1, 32'd100000, 32'd0, 1'b1, 8'd255, 8'd255, 0, 0, "sat_div0"};
        tbl[2]  = '{32'd0, 32'd7, 32'd8, 32'd9, 1'b0, 8'd0, 8'd0, 0, 0, "cnt0"};
        tbl[3]  = '{32'd1, 32'd3, 32'd10, 32'd7, 1'b1, 8'd53, 8'd22, 0, 0, "odd_floor"};
        tbl[4]  = '{32'd1, 32'd5, 32'd0, 32'd5, 1'b1, 8'd0, 8'd0, 0, 0, "g_zero"};
        tbl[5]  = '{32'd1, 32'd0, 32'd0, 32'd16, 1'b1, 8'd255, 8'd0, 0, 0, "r_zero_g_zero"};
        tbl[6]  = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1000, 1'b1, 8'd16, 8'd255, 0, 0, "max_sums"};
        tbl[7]  = '{32'd2, 32'd100, 32'd1600, 32'd1601, 1'b1, 8'd255, 8'd15, 0, 0, "sat_256"};
        tbl[8]  = '{32'd2, 32'd100, 32'd1599, 32'd1600, 1'b1, 8'd255, 8'd15, 0, 0, "below_sat"};
        tbl[9]  = '{32'd10, 32'd1000, 32'd2000, 32'd4000, 1'b1, 8'd32, 8'd8, 20, 0, "ignore_second"};
        tbl[10] = '{32'd10, 32'd1000, 32'd2000, 32'd4000, 1'b0, 8'd0, 8'd0, 0, 40, "reset_mid"};
        tbl[11] = '{32'd3, 32'd400, 32'd500, 32'd800, 1'b1, 8'd20, 8'd10, 0, 0, "after_reset"};

        rst_n = 1'b0; in_done = 1'b0;
        in_cnt = '0; in_sum_r = '0; in_sum_g = '0; in_sum_b = '0;
        repeat (3) @(negedge pclk);
        check("in_reset_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge pclk);
        check("reset_r_gain", out_r_gain, 16);
        check("reset_g_gain", out_g_gain, 16);
        check("reset_b_gain", out_b_gain, 16);
        check("reset_valid", out_valid, 0);
        check("reset_busy", out_busy, 0);

        for (int i = 0; i < 12; i++) run_frame(tbl[i]);

        // New frame accepted in the very cycle out_valid is high.
        @(negedge pclk);
        in_cnt = 32'd3; in_sum_r = 32'd300; in_sum_g = 32'd600; in_sum_b = 32'd150;
        in_done = 1'b1;
        @(negedge pclk);
        in_done = 1'b0;
        first = 0; second = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge pclk);
            in_done = 1'b0;
            if (out_valid && first == 0) begin
                first = n;
                check("b2b_first_r", out_r_gain, 32);
                check("b2b_first_b", out_b_gain, 64);
                in_cnt = 32'd4; in_sum_r = 32'd50; in_sum_g = 32'd60; in_sum_b = 32'd40;
                in_done = 1'b1;
            end else if (out_valid && second == 0) begin
                second = n;
            end
        end
        check("b2b_first_latency", first, LAT);
        check("b2b_second_latency", second, 2 * LAT + 1);
        check("b2b_second_r", out_r_gain, 19);
        check("b2b_second_b", out_b_gain, 24);
        cur_r = 8'd19; cur_b = 8'd24;

        for (int k = 0; k < 20; k++) begin
            v.cnt    = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            v.sr     = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1 << 20));
            v.sb     = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1 << 20));
            v.sg     = 32'($urandom_range(0, 1 << 20));
            v.ev     = (v.cnt != 0);
            v.er     = ref_gain(v.sg, v.sr);
            v.eb     = ref_gain(v.sg, v.sb);
            v.inj_at = 0;
            v.rst_at = 0;
            v.tag    = $sformatf("rand%0d", k);
            run_frame(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/isp_awb_gain_calc.md
# isp_awb_gain_calc

Consumes the per-frame white-balance statistics (valid-pixel count and R/G/B sums) emitted by the AWB statistics stage at frame end. Computes gray-world channel gains, G/R and G/B, in unsigned fixed point using one shared serial divider. The G gain is fixed at unity. Results are held stable for the downstream WB gain multiplier, and each new gain set is announced with a one-cycle valid pulse.

## Interface
- STAT_BITS, 32, width of count/sum inputs
- GAIN_BITS, 8, width of each output gain
- GAIN_FRAC, 4, fractional bits of gains (unity = 1<<GAIN_FRAC = 16)
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- in_done  in  1  one-cycle pulse: statistics below valid this cycle
- in_cnt  in  STAT_BITS  valid-pixel count of last frame
- in_sum_r / in_sum_g / in_sum_b  in  STAT_BITS each  channel sums of last frame
- out_r_gain / out_g_gain / out_b_gain  out  GAIN_BITS each  current gains, Q(GAIN_BITS-GAIN_FRAC).GAIN_FRAC
- out_valid  out  1  one-cycle pulse: new gains just loaded
- out_busy  out  1  high while a computation is in progress

## Operation
- Reset: all three gains = unity (16); out_valid = 0; out_busy = 0; FSM = IDLE.
- FSM states: IDLE, DIV_R, DIV_B, LOAD.
  - IDLE: on in_done=1, latch the sums and the count, then go to DIV_R.
  - If the latched in_cnt == 0, go directly to IDLE: no valid pulse, gains held.
- QW = STAT_BITS + GAIN_FRAC (36 by default).
- DIV_R: restoring division, dividend = sum_g << GAIN_FRAC, divisor = sum_r.
  - One quotient bit per cycle, MSB first.
  - QW cycles, then store the quotient and go to DIV_B.
- DIV_B: the same divider with divisor sum_b, QW cycles, then go to LOAD.
- LOAD: saturate each quotient to 2^GAIN_BITS-1 (255), load out_r_gain and out_b_gain, pulse out_valid, go to IDLE.
- Quotient is floor, with no rounding. All intermediates are unsigned and QW+1 bits wide, so nothing overflows.
- Divisor == 0: the quotient is forced to the saturated maximum (255), including when sum_g == 0.
- sum_g == 0 with a nonzero divisor gives gain 0.
- out_g_gain is constant unity in all states.
- out_busy = 1 in DIV_R, DIV_B and LOAD.
- in_done while out_busy: ignored. The pulse is dropped, latched operands are not disturbed, and no queueing occurs.
- Gains change only on the LOAD edge and are stable otherwise.
- rst_n asserted mid-computation: immediate return to the reset values, and the partial result is discarded.

## Timing
- Edge 0 samples in_done=1, latching the operands and entering DIV_R.
- Edges 1..QW: R-division iterations.
- Edges QW+1..2QW: B-division iterations.
- Edge 2QW+1 (LOAD) updates the gains and drives out_valid high for exactly the following cycle.
- Latency from in_done to out_valid is 2QW+1 = 73 cycles by default, far below any vertical blanking interval.
- out_busy rises after edge 0 and falls after edge 2QW+1. A new in_done is accepted on the same cycle out_valid is high.
- The cnt==0 drop path takes one cycle. out_busy may pulse for that one cycle only.

## Structure
- Package isp_awb_pkg holds:
  - FSM state encoding (IDLE, DIV_R, DIV_B, LOAD)
  - localparam helpers QW and UNITY_GAIN
  - the saturation limit
- One sub-module, isp_seq_div: a restoring serial divider.
  - Interface: start, dividend[QW], divisor[STAT_BITS], busy, done, quotient[QW].
  - It handles divide-by-zero internally (quotient = all ones).
  - It is instantiated once and reused for R, then B.
- Top-level work is limited to the FSM, operand latch and output saturation.

## Test plan
- Reset, no stimulus: gains 16/16/16, out_valid 0, out_busy 0.
- cnt=10, sum_r=1000, sum_g=2000, sum_b=4000: after 73 cycles out_valid pulses once, with r_gain 32 (2.0), g_gain 16, b_gain 8 (0.5).
- cnt=5, sum_r=1, sum_g=100000, sum_b=0: r_gain 255 and b_gain 255 (saturation and divide-by-zero).
- cnt=0 with any sums: no out_valid within 200 cycles, and gains unchanged from the prior frame.
- Second in_done at cycle 20 of a computation: ignored, and the results equal the first frame's values.
- rst_n pulsed low at cycle 40 of a computation: gains return to 16, and no out_valid follows.
